// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage register addresses and control in,
// forwarding selects, stall/flush controls and the stall counter out.
interface hazard_stall_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_jump_taken;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_reg_write;
    logic                  mem_req;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_reg_write;

    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic                  stall_if;
    logic                  stall_id;
    logic                  stall_ex;
    logic                  stall_mem;
    logic                  flush_id;
    logic                  flush_ex;
    logic                  flush_wb;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_jump_taken,
        output mem_rd, mem_reg_write, mem_req, mem_ready,
        output wb_rd, wb_reg_write,
        input  fwd_a, fwd_b, stall_if, stall_id, stall_ex, stall_mem,
        input  flush_id, flush_ex, flush_wb, mem_timeout, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_jump_taken,
        input  mem_rd, mem_reg_write, mem_req, mem_ready,
        input  wb_rd, wb_reg_write,
        output fwd_a, fwd_b, stall_if, stall_id, stall_ex, stall_mem,
        output flush_id, flush_ex, flush_wb, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage core: operand forwarding, load-use bubbles,
// jump flushes, data-memory wait FSM with timeout and a stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int unsigned REG_ADDR_W  = 4,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_stall_ctrl_if.slave bus
);
    localparam int unsigned TW = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   wait_cnt;
    logic [TW-1:0]   wait_cnt_nxt;
    logic            last_wait;
    logic            timeout_hit;
    logic            mem_stall;
    logic            load_use;
    logic            mem_timeout_q;
    logic [CNT_W-1:0] stall_cnt;

    logic [1:0]      fwd_a_c;
    logic [1:0]      fwd_b_c;
    logic            stall_if_c;
    logic            stall_id_c;
    logic            stall_ex_c;
    logic            stall_mem_c;
    logic            flush_id_c;
    logic            flush_ex_c;
    logic            flush_wb_c;

    // Final wait cycle: the access is abandoned here unless memory answers.
    assign last_wait   = (state == MEM_WAIT) && (wait_cnt == TW'(MEM_TIMEOUT - 1));
    assign timeout_hit = last_wait && !bus.mem_ready;
    assign mem_stall   = bus.mem_req && !bus.mem_ready && !last_wait;

    assign load_use = bus.ex_mem_read && (bus.ex_rd != '0) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = TW'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready || last_wait) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + TW'(1);
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Forwarding selects, then stall/flush priority: memory wait > jump > load-use.
    always_comb begin
        fwd_a_c     = 2'b00;
        fwd_b_c     = 2'b00;
        stall_if_c  = 1'b0;
        stall_id_c  = 1'b0;
        stall_ex_c  = 1'b0;
        stall_mem_c = 1'b0;
        flush_id_c  = 1'b0;
        flush_ex_c  = 1'b0;
        flush_wb_c  = 1'b0;

        if (bus.mem_reg_write && (bus.mem_rd == bus.ex_rs1) && (bus.ex_rs1 != '0))
            fwd_a_c = 2'b10;
        else if (bus.wb_reg_write && (bus.wb_rd == bus.ex_rs1) && (bus.ex_rs1 != '0))
            fwd_a_c = 2'b01;

        if (bus.mem_reg_write && (bus.mem_rd == bus.ex_rs2) && (bus.ex_rs2 != '0))
            fwd_b_c = 2'b10;
        else if (bus.wb_reg_write && (bus.wb_rd == bus.ex_rs2) && (bus.ex_rs2 != '0))
            fwd_b_c = 2'b01;

        if (mem_stall) begin
            stall_if_c  = 1'b1;
            stall_id_c  = 1'b1;
            stall_ex_c  = 1'b1;
            stall_mem_c = 1'b1;
            flush_wb_c  = 1'b1;
        end else if (bus.ex_jump_taken) begin
            flush_id_c = 1'b1;
            flush_ex_c = 1'b1;
        end else if (load_use) begin
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            flush_ex_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_timeout_q <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            mem_timeout_q <= timeout_hit;
            stall_cnt     <= stall_cnt + CNT_W'(stall_if_c);
        end
    end

    assign bus.fwd_a        = fwd_a_c;
    assign bus.fwd_b        = fwd_b_c;
    assign bus.stall_if     = stall_if_c;
    assign bus.stall_id     = stall_id_c;
    assign bus.stall_ex     = stall_ex_c;
    assign bus.stall_mem    = stall_mem_c;
    assign bus.flush_id     = flush_id_c;
    assign bus.flush_ex     = flush_ex_c;
    assign bus.flush_wb     = flush_wb_c;
    assign bus.mem_timeout  = mem_timeout_q;
    assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: expected outputs queued per step and
// popped on the falling edge for comparison.
module tb_hazard_stall_ctrl;
    logic clk;
    logic rst;

    hazard_stall_ctrl_if #(.REG_ADDR_W(4), .CNT_W(32)) bus ();

    hazard_stall_ctrl #(
        .REG_ADDR_W (4),
        .MEM_TIMEOUT(4),
        .CNT_W      (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [3:0]  st;   // stall_if, stall_id, stall_ex, stall_mem
        logic [2:0]  fl;   // flush_id, flush_ex, flush_wb
        logic        mto;
        logic [31:0] sc;
    } exp_t;

    exp_t        sbq[$];
    int          errors;
    int          checks;
    logic [31:0] exp_sc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_rd = '0;
        bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_jump_taken = 1'b0;
        bus.mem_rd = '0; bus.mem_reg_write = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
        bus.wb_rd = '0; bus.wb_reg_write = 1'b0;
    endtask

    // Queue the expectation; the counter model advances on any expected stall_if.
    task automatic push(input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] st,
                        input logic [2:0] fl, input logic mto);
        exp_t e;
        e = '{fa: fa, fb: fb, st: st, fl: fl, mto: mto, sc: exp_sc};
        sbq.push_back(e);
        if (st[3]) exp_sc = exp_sc + 32'd1;
    endtask

    task automatic check(input string tag);
        exp_t e;
        exp_t obs;
        @(negedge clk);
        obs.fa  = bus.fwd_a;
        obs.fb  = bus.fwd_b;
        obs.st  = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem};
        obs.fl  = {bus.flush_id, bus.flush_ex, bus.flush_wb};
        obs.mto = bus.mem_timeout;
        obs.sc  = bus.stall_cycles;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL %s observed=%h expected=<empty queue>", tag, obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_sc = 32'd0;
        rst    = 1'b1;
        idle();
        @(posedge clk);
        #1;
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        check("reset");
        rst = 1'b0;

        // Load-use bubble then forward from MEM on the following cycle
        idle(); bus.ex_rd = 4'd3; bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1;
        bus.id_rs1 = 4'd3; bus.id_use_rs1 = 1'b1;
        push(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0); check("load_use_rs1");
        idle(); bus.mem_rd = 4'd3; bus.mem_reg_write = 1'b1; bus.ex_rs1 = 4'd3;
        push(2'b10, 2'b00, 4'b0000, 3'b000, 1'b0); check("fwd_a_mem_after_bubble");

        idle(); bus.mem_rd = 4'd5; bus.mem_reg_write = 1'b1; bus.wb_rd = 4'd5;
        bus.wb_reg_write = 1'b1; bus.ex_rs2 = 4'd5;
        push(2'b00, 2'b10, 4'b0000, 3'b000, 1'b0); check("fwd_b_mem_priority");
        idle(); bus.wb_rd = 4'd7; bus.wb_reg_write = 1'b1; bus.ex_rs1 = 4'd7;
        bus.mem_rd = 4'd2; bus.mem_reg_write = 1'b1;
        push(2'b01, 2'b00, 4'b0000, 3'b000, 1'b0); check("fwd_a_wb");
        idle(); bus.mem_reg_write = 1'b1; bus.wb_reg_write = 1'b1;
        bus.ex_mem_read = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0); check("rd_zero_no_fwd_no_stall");
        idle(); bus.mem_rd = 4'd5; bus.ex_rs1 = 4'd5; bus.ex_mem_read = 1'b1;
        bus.ex_rd = 4'd6; bus.id_rs2 = 4'd6;
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0); check("no_write_no_use");
        idle(); bus.ex_mem_read = 1'b1; bus.ex_rd = 4'd9; bus.id_rs2 = 4'd9; bus.id_use_rs2 = 1'b1;
        push(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0); check("load_use_rs2");
        bus.ex_jump_taken = 1'b1;
        push(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0); check("jump_over_load_use");
        idle();
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0); check("jump_counter_unchanged");

        // Three-cycle memory wait with a jump held pending
        idle(); bus.mem_req = 1'b1; bus.ex_jump_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0); check("mem_wait_stall");
        end
        bus.mem_ready = 1'b1;
        push(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0); check("mem_release_jump_flush");
        idle();
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0); check("no_timeout_after_ready");
        idle(); bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0); check("zero_wait_access");

        // Timeout: memory never answers
        idle(); bus.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0); check("timeout_stall");
        end
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0); check("timeout_release");
        idle();
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b1); check("timeout_pulse");
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0); check("timeout_pulse_single");

        // Reset in the second cycle of MEM_WAIT
        idle(); bus.mem_req = 1'b1;
        push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0); check("rst_wait_enter");
        push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0); check("rst_wait_c1");
        rst = 1'b1;
        push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0); check("rst_wait_c2");
        exp_sc = 32'd0;
        rst = 1'b0;
        idle();
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0); check("after_rst_cleared");
        idle(); bus.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0); check("post_rst_full_wait");
        end
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0); check("post_rst_release");
        idle();
        push(2'b00, 2'b00, 4'b0000, 3'b000, 1'b1); check("post_rst_timeout_pulse");

        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL leftover_queue observed=%0d expected=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
